wordle_engine: RTL and testbench

WORDLE_ENGINE -- requirements
Module: wordle_engine

---
 rtl/wordle_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_wordle_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_engine.sv
// wordle_engine: Wordle game controller with letter entry, serial duplicate-aware scoring and win/lose tracking.
// Define WORDLE_HARD_MODE_EN to require every previously found green letter to be reused in later guesses.
module wordle_engine #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6
) (
    input  logic                             Clk,
    input  logic                             reset_n,
    input  logic                             Start,
    input  logic                             C,
    input  logic                             BkSp,
    input  logic                             Enter,
    input  logic                             Ack,
    input  logic [7:0]                       curr_letter,
    input  logic [8*WORD_LEN-1:0]            randomWord,
    output logic [8*WORD_LEN-1:0]            guess_word,
    output logic [$clog2(WORD_LEN+1)-1:0]    I,
    output logic [$clog2(MAX_GUESSES+1)-1:0] guess_cnt,
    output logic [2*WORD_LEN-1:0]            score,
    output logic                             score_valid,
    output logic                             q_I,
    output logic                             q_Entry,
    output logic                             q_Score,
    output logic                             q_Done,
    output logic                             win,
    output logic                             lose,
    output logic                             reject
);

    localparam int IW = $clog2(WORD_LEN+1);
    localparam int GW = $clog2(MAX_GUESSES+1);

    typedef enum logic [3:0] {
        ST_I     = 4'b0001,
        ST_ENTRY = 4'b0010,
        ST_SCORE = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    state_t state, state_next;

    logic [7:0]            guess_l  [WORD_LEN];
    logic [7:0]            target_l [WORD_LEN];
    logic [WORD_LEN-1:0]   match_vec;
    logic [WORD_LEN-1:0]   green_reg;
    logic [WORD_LEN-1:0]   used, used_next;
    logic [2*WORD_LEN-1:0] work, work_next;
    logic [IW-1:0]         step;
    logic                  found;

    logic is_full, do_bksp, enter_sel, do_commit, enter_ok, do_reject;
    logic hard_violation, score_last, all_green, last_guess;

    // Letter 0 lives in the most significant byte of both words.
    for (genvar g = 0; g < WORD_LEN; g++) begin : g_letters
        assign guess_l[g]   = guess_word[8*(WORD_LEN-1-g) +: 8];
        assign target_l[g]  = randomWord[8*(WORD_LEN-1-g) +: 8];
        assign match_vec[g] = (guess_l[g] == target_l[g]);
    end

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0] green_mask;
    assign hard_violation = |(green_mask & ~match_vec);
`else
    assign hard_violation = 1'b0;
`endif

    // BkSp outranks Enter, which outranks C; the winning command owns the cycle even if it is a no-op.
    assign is_full    = (I == IW'(WORD_LEN));
    assign do_bksp    = (state == ST_ENTRY) && BkSp && (I != '0);
    assign enter_sel  = (state == ST_ENTRY) && !BkSp && Enter;
    assign do_commit  = (state == ST_ENTRY) && !BkSp && !Enter && C && !is_full;
    assign enter_ok   = enter_sel && is_full && !hard_violation;
    assign do_reject  = enter_sel && is_full && hard_violation;
    assign score_last = (state == ST_SCORE) && (step == IW'(WORD_LEN));
    assign all_green  = &green_reg;
    assign last_guess = ((guess_cnt + GW'(1)) == GW'(MAX_GUESSES));

    assign q_I     = (state == ST_I);
    assign q_Entry = (state == ST_ENTRY);
    assign q_Score = (state == ST_SCORE);
    assign q_Done  = (state == ST_DONE);

    // Step 0 claims all greens at once; step k then lets guess letter k-1 claim the lowest unused target slot.
    always_comb begin
        work_next = work;
        used_next = used;
        found     = 1'b0;
        if (step == '0) begin
            used_next = match_vec;
            work_next = '0;
            for (int i = 0; i < WORD_LEN; i++) begin
                if (match_vec[i]) begin
                    work_next[2*i +: 2] = 2'b10;
                end
            end
        end else begin
            for (int k = 0; k < WORD_LEN; k++) begin
                if ((step == IW'(k+1)) && !green_reg[k]) begin
                    for (int j = 0; j < WORD_LEN; j++) begin
                        if (!found && !used[j] && (target_l[j] == guess_l[k])) begin
                            found               = 1'b1;
                            used_next[j]        = 1'b1;
                            work_next[2*k +: 2] = 2'b01;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_I:     if (Start)    state_next = ST_ENTRY;
            ST_ENTRY: if (enter_ok) state_next = ST_SCORE;
            ST_SCORE: if (score_last) state_next = (all_green || last_guess) ? ST_DONE : ST_ENTRY;
            ST_DONE:  if (Ack)      state_next = ST_I;
            default:                state_next = ST_I;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_I;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            guess_word  <= '0;
            I           <= '0;
            guess_cnt   <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            reject      <= 1'b0;
            green_reg   <= '0;
            used        <= '0;
            work        <= '0;
            step        <= '0;
`ifdef WORDLE_HARD_MODE_EN
            green_mask  <= '0;
`endif
        end else begin
            score_valid <= 1'b0;
            reject      <= 1'b0;

            if ((state == ST_I) && Start) begin
                guess_word <= '0;
                I          <= '0;
                guess_cnt  <= '0;
                score      <= '0;
                win        <= 1'b0;
                lose       <= 1'b0;
`ifdef WORDLE_HARD_MODE_EN
                green_mask <= '0;
`endif
            end

            if (do_bksp) begin
                for (int p = 0; p < WORD_LEN; p++) begin
                    if (IW'(p) == (I - IW'(1))) begin
                        guess_word[8*(WORD_LEN-1-p) +: 8] <= '0;
                    end
                end
                I <= I - IW'(1);
            end

            if (do_commit) begin
                for (int p = 0; p < WORD_LEN; p++) begin
                    if (IW'(p) == I) begin
                        guess_word[8*(WORD_LEN-1-p) +: 8] <= curr_letter;
                    end
                end
                I <= I + IW'(1);
            end

            if (do_reject) begin
                reject <= 1'b1;
            end

            if (enter_ok) begin
                step <= '0;
            end

            if (state == ST_SCORE) begin
                step <= step + IW'(1);
                work <= work_next;
                used <= used_next;
                if (step == '0) begin
                    green_reg <= match_vec;
                end
                if (score_last) begin
                    score       <= work_next;
                    score_valid <= 1'b1;
                    guess_cnt   <= guess_cnt + GW'(1);
`ifdef WORDLE_HARD_MODE_EN
                    green_mask  <= green_mask | green_reg;
`endif
                    if (all_green) begin
                        win <= 1'b1;
                    end else if (last_guess) begin
                        lose <= 1'b1;
                    end else begin
                        guess_word <= '0;
                        I          <= '0;
                    end
                end
            end

            if ((state == ST_DONE) && Ack) begin
                win  <= 1'b0;
                lose <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wordle_engine.sv
// tb_wordle_engine: directed self-checking bench for wordle_engine (WORD_LEN=5, MAX_GUESSES=6).
// Hard-mode expectations switch on WORDLE_HARD_MODE_EN, matching the design build.
module tb_wordle_engine;

    localparam int WL = 5;
    localparam int MG = 6;

    localparam logic [39:0] W_CRANE = "CRANE";
    localparam logic [39:0] W_SPEED = "SPEED";
    localparam logic [39:0] W_ZZZZZ = "ZZZZZ";
    localparam logic [39:0] W_ZZANE = "ZZANE";

    logic            Clk, reset_n, Start, C, BkSp, Enter, Ack;
    logic [7:0]      curr_letter;
    logic [8*WL-1:0] randomWord, guess_word;
    logic [2:0]      I, guess_cnt;
    logic [2*WL-1:0] score;
    logic            score_valid, q_I, q_Entry, q_Score, q_Done, win, lose, reject;

    int vectors     = 0;
    int miscompares = 0;

    wordle_engine #(.WORD_LEN(WL), .MAX_GUESSES(MG)) dut (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .C(C), .BkSp(BkSp), .Enter(Enter), .Ack(Ack),
        .curr_letter(curr_letter), .randomWord(randomWord), .guess_word(guess_word), .I(I),
        .guess_cnt(guess_cnt), .score(score), .score_valid(score_valid), .q_I(q_I), .q_Entry(q_Entry),
        .q_Score(q_Score), .q_Done(q_Done), .win(win), .lose(lose), .reject(reject)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        {Start, C, BkSp, Enter, Ack} = '0;
        curr_letter = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_game(input logic [39:0] w);
        randomWord = w;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic type_letter(input logic [7:0] l);
        C = 1'b1;
        curr_letter = l;
        tick();
        C = 1'b0;
    endtask

    task automatic type_word(input string s);
        for (int i = 0; i < WL; i++) type_letter(s[i]);
    endtask

    task automatic press_bksp();
        BkSp = 1'b1;
        tick();
        BkSp = 1'b0;
    endtask

    task automatic press_enter();
        Enter = 1'b1;
        tick();
        Enter = 1'b0;
    endtask

    task automatic press_ack();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    // Returns the number of cycles after the Enter edge until score_valid, or 0 on timeout.
    task automatic wait_score(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (score_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({q_I, q_Entry, q_Score, q_Done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b, expected 1000", {q_I, q_Entry, q_Score, q_Done});
        end
        vectors++;
        if ({guess_word, I, guess_cnt, score, score_valid, win, lose, reject} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got word=%h I=%0d cnt=%0d score=%h sv=%b w=%b l=%b r=%b, expected all 0",
                     guess_word, I, guess_cnt, score, score_valid, win, lose, reject);
        end
    endtask

    task automatic test_win();
        int n;
        do_reset();
        start_game(W_CRANE);
        vectors++;
        if ({q_I, q_Entry, q_Score, q_Done} !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL start_entry: got %b, expected 0100", {q_I, q_Entry, q_Score, q_Done});
        end
        type_word("CRANE");
        vectors++;
        if (guess_word !== W_CRANE || I !== 3'd5) begin
            miscompares++;
            $display("[TB] FAIL type_crane: got %h I=%0d, expected %h I=5", guess_word, I, W_CRANE);
        end
        press_enter();
        vectors++;
        if ({q_I, q_Entry, q_Score, q_Done} !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL enter_score: got %b, expected 0010", {q_I, q_Entry, q_Score, q_Done});
        end
        // Keys pressed while scoring must have no effect.
        C = 1'b1;
        Start = 1'b1;
        curr_letter = "X";
        wait_score(n);
        C = 1'b0;
        Start = 1'b0;
        vectors++;
        if (n !== 6) begin
            miscompares++;
            $display("[TB] FAIL win_latency: got %0d, expected 6", n);
        end
        vectors++;
        if (score !== 10'h2AA || win !== 1'b1 || lose !== 1'b0 || q_Done !== 1'b1 || guess_cnt !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL win_result: got score=%h win=%b lose=%b done=%b cnt=%0d, expected 2aa 1 0 1 1",
                     score, win, lose, q_Done, guess_cnt);
        end
        vectors++;
        if (guess_word !== W_CRANE) begin
            miscompares++;
            $display("[TB] FAIL win_word_hold: got %h, expected %h", guess_word, W_CRANE);
        end
        tick();
        vectors++;
        if (score_valid !== 1'b0 || q_Done !== 1'b1 || win !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL win_pulse: got sv=%b done=%b win=%b, expected 0 1 1", score_valid, q_Done, win);
        end
        press_ack();
        vectors++;
        if (q_I !== 1'b1 || win !== 1'b0 || score !== 10'h2AA) begin
            miscompares++;
            $display("[TB] FAIL win_ack: got qI=%b win=%b score=%h, expected 1 0 2aa", q_I, win, score);
        end
    endtask

    task automatic test_yellow(input logic [39:0] target, input string guess,
                               input logic [9:0] exp_score, input string name);
        int n;
        do_reset();
        start_game(target);
        type_word(guess);
        press_enter();
        wait_score(n);
        vectors++;
        if (n !== 6 || score !== exp_score) begin
            miscompares++;
            $display("[TB] FAIL %s_score: got score=%h after %0d cycles, expected %h after 6", name, score, n, exp_score);
        end
        vectors++;
        if (q_Entry !== 1'b1 || I !== 3'd0 || guess_word !== '0 || guess_cnt !== 3'd1 || win !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_return: got entry=%b I=%0d word=%h cnt=%0d win=%b, expected 1 0 0 1 0",
                     name, q_Entry, I, guess_word, guess_cnt, win);
        end
    endtask

    task automatic test_lose();
        int n;
        do_reset();
        start_game(W_CRANE);
        for (int g = 1; g <= MG; g++) begin
            type_word("ZZZZZ");
            press_enter();
            wait_score(n);
            vectors++;
            if (n !== 6 || guess_cnt !== 3'(g)) begin
                miscompares++;
                $display("[TB] FAIL lose_guess%0d: got cnt=%0d after %0d cycles, expected %0d after 6", g, guess_cnt, n, g);
            end
            if (g < MG) begin
                vectors++;
                if (q_Entry !== 1'b1 || lose !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL lose_continue%0d: got entry=%b lose=%b, expected 1 0", g, q_Entry, lose);
                end
            end
        end
        vectors++;
        if (q_Done !== 1'b1 || lose !== 1'b1 || win !== 1'b0 || score !== '0 || guess_word !== W_ZZZZZ) begin
            miscompares++;
            $display("[TB] FAIL lose_result: got done=%b lose=%b win=%b score=%h word=%h, expected 1 1 0 0 %h",
                     q_Done, lose, win, score, guess_word, W_ZZZZZ);
        end
        press_ack();
        vectors++;
        if (q_I !== 1'b1 || lose !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lose_ack: got qI=%b lose=%b, expected 1 0", q_I, lose);
        end
    endtask

    task automatic test_edit();
        do_reset();
        start_game(W_CRANE);
        type_letter("C");
        type_letter("R");
        type_letter("A");
        type_letter("T");
        press_bksp();
        vectors++;
        if (I !== 3'd3 || guess_word !== 40'h4352410000) begin
            miscompares++;
            $display("[TB] FAIL edit_bksp: got I=%0d word=%h, expected 3 4352410000", I, guess_word);
        end
        press_bksp();
        C = 1'b1;
        BkSp = 1'b1;
        curr_letter = "Q";
        tick();
        C = 1'b0;
        BkSp = 1'b0;
        vectors++;
        if (I !== 3'd1 || guess_word !== 40'h4300000000) begin
            miscompares++;
            $display("[TB] FAIL edit_priority: got I=%0d word=%h, expected 1 4300000000", I, guess_word);
        end
        press_enter();
        vectors++;
        if ({q_I, q_Entry, q_Score, q_Done} !== 4'b0100 || I !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL edit_short_enter: got state=%b I=%0d, expected 0100 1", {q_I, q_Entry, q_Score, q_Done}, I);
        end
        press_bksp();
        press_bksp();
        vectors++;
        if (I !== 3'd0 || guess_word !== '0) begin
            miscompares++;
            $display("[TB] FAIL edit_empty_bksp: got I=%0d word=%h, expected 0 0", I, guess_word);
        end
        type_word("CRANE");
        type_letter("Q");
        vectors++;
        if (I !== 3'd5 || guess_word !== W_CRANE) begin
            miscompares++;
            $display("[TB] FAIL edit_full_commit: got I=%0d word=%h, expected 5 %h", I, guess_word, W_CRANE);
        end
    endtask

    task automatic test_reset_in_score();
        int n;
        logic seen;
        do_reset();
        start_game(W_CRANE);
        type_word("EERIE");
        press_enter();
        wait_score(n);
        type_word("CRANE");
        press_enter();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({q_I, q_Entry, q_Score, q_Done} !== 4'b1000 ||
            {guess_word, I, guess_cnt, score, score_valid, win, lose, reject} !== '0) begin
            miscompares++;
            $display("[TB] FAIL score_reset: got state=%b word=%h I=%0d cnt=%0d score=%h sv=%b, expected 1000 and zeros",
                     {q_I, q_Entry, q_Score, q_Done}, guess_word, I, guess_cnt, score, score_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen |= score_valid;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen |= score_valid;
        end
        vectors++;
        if (seen !== 1'b0 || q_I !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL score_reset_quiet: got sv_seen=%b qI=%b, expected 0 1", seen, q_I);
        end
        start_game(W_CRANE);
        vectors++;
        if (q_Entry !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL score_reset_resume: got entry=%b, expected 1", q_Entry);
        end
    endtask

    task automatic test_hard_mode();
        int n;
        do_reset();
        start_game(W_CRANE);
        type_word("CRZZZ");
        press_enter();
        wait_score(n);
        vectors++;
        if (n !== 6 || score !== 10'h00A || q_Entry !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hard_first: got score=%h entry=%b after %0d cycles, expected 00a 1 after 6", score, q_Entry, n);
        end
        type_word("ZZANE");
        press_enter();
`ifdef WORDLE_HARD_MODE_EN
        vectors++;
        if (reject !== 1'b1 || q_Entry !== 1'b1 || I !== 3'd5 || guess_word !== W_ZZANE) begin
            miscompares++;
            $display("[TB] FAIL hard_reject: got rej=%b entry=%b I=%0d word=%h, expected 1 1 5 %h",
                     reject, q_Entry, I, guess_word, W_ZZANE);
        end
        tick();
        vectors++;
        if (reject !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hard_reject_pulse: got %b, expected 0", reject);
        end
        for (int k = 0; k < WL; k++) press_bksp();
        type_word("CRONE");
        press_enter();
        vectors++;
        if (q_Score !== 1'b1 || reject !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hard_accept: got score_state=%b rej=%b, expected 1 0", q_Score, reject);
        end
`else
        vectors++;
        if (reject !== 1'b0 || q_Score !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL easy_accept: got rej=%b score_state=%b, expected 0 1", reject, q_Score);
        end
`endif
    endtask

    initial begin
        {Start, C, BkSp, Enter, Ack} = '0;
        curr_letter = '0;
        randomWord  = '0;
        reset_n     = 1'b1;
        $display("[TB] starting wordle_engine bench");
        test_reset();
        test_win();
        test_yellow(W_CRANE, "EERIE", 10'h210, "eerie");
        test_yellow(W_SPEED, "EERIE", 10'h005, "dupes");
        test_lose();
        test_edit();
        test_reset_in_score();
        test_hard_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
